// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and defaults for the fetch flow controller
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2,
    ST_STALL  = 2'd3
  } fetch_ctrl_state_t;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_EXT  = 3'd1,
    SRC_MP0  = 3'd2,
    SRC_MP1  = 3'd3,
    SRC_MP2  = 3'd4
  } redirect_src_t;

  localparam int DEFAULT_STALL_HI = 13;
  localparam int DEFAULT_STALL_LO = 9;

endpackage

// File: rtl/redirect_select.sv
// rtl/redirect_select.sv - priority pick of redirect source and its target PC
module redirect_select
  import fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ext_redirect_i,
  input  logic [DATA_WIDTH-1:0] ext_redirect_pc_i,
  input  logic [2:0]            mispredict_i,
  input  logic [DATA_WIDTH-1:0] mispredict_pc_0_i,
  input  logic [DATA_WIDTH-1:0] mispredict_pc_1_i,
  input  logic [DATA_WIDTH-1:0] mispredict_pc_2_i,
  output logic                  redirect_req_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o
);

  redirect_src_t src;

  // Traps beat mispredictions; among slots the oldest (bit 0) wins.
  always_comb begin
    src = SRC_NONE;
    if (ext_redirect_i)       src = SRC_EXT;
    else if (mispredict_i[0]) src = SRC_MP0;
    else if (mispredict_i[1]) src = SRC_MP1;
    else if (mispredict_i[2]) src = SRC_MP2;
  end

  always_comb begin
    redirect_pc_o = '0;
    case (src)
      SRC_EXT: redirect_pc_o = ext_redirect_pc_i;
      SRC_MP0: redirect_pc_o = mispredict_pc_0_i;
      SRC_MP1: redirect_pc_o = mispredict_pc_1_i;
      SRC_MP2: redirect_pc_o = mispredict_pc_2_i;
      default: redirect_pc_o = '0;
    endcase
  end

  assign redirect_req_o = (src != SRC_NONE);

endmodule

// File: rtl/fetch_flow_controller.sv
// rtl/fetch_flow_controller.sv - redirect/flush sequencing and occupancy backpressure for 3-wide fetch
module fetch_flow_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int BUFFER_DEPTH  = 16,
  parameter int STALL_HI      = DEFAULT_STALL_HI,
  parameter int STALL_LO      = DEFAULT_STALL_LO,
  parameter int REFILL_CYCLES = 1,
  parameter int CNT_WIDTH     = 16,
  localparam int OCC_W        = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_redirect_i,
  input  logic [DATA_WIDTH-1:0] ext_redirect_pc_i,
  input  logic [2:0]            mispredict_i,
  input  logic [DATA_WIDTH-1:0] mispredict_pc_0_i,
  input  logic [DATA_WIDTH-1:0] mispredict_pc_1_i,
  input  logic [DATA_WIDTH-1:0] mispredict_pc_2_i,
  input  logic [OCC_W-1:0]      occupancy_i,
  output logic                  flush_o,
  output logic [DATA_WIDTH-1:0] correct_pc_o,
  output logic                  buble_o,
  output logic [1:0]            state_o,
  output logic [CNT_WIDTH-1:0]  flush_count_o,
  output logic [CNT_WIDTH-1:0]  stall_count_o
);

  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

  if (!(STALL_LO < STALL_HI && STALL_HI <= BUFFER_DEPTH && REFILL_CYCLES >= 1)) begin : g_bad_params
    $fatal(1, "fetch_flow_controller: illegal STALL_LO/STALL_HI/BUFFER_DEPTH/REFILL_CYCLES");
  end

  logic                  redirect_req;
  logic [DATA_WIDTH-1:0] redirect_pc;

  redirect_select #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_redirect_select (
    .ext_redirect_i    (ext_redirect_i),
    .ext_redirect_pc_i (ext_redirect_pc_i),
    .mispredict_i      (mispredict_i),
    .mispredict_pc_0_i (mispredict_pc_0_i),
    .mispredict_pc_1_i (mispredict_pc_1_i),
    .mispredict_pc_2_i (mispredict_pc_2_i),
    .redirect_req_o    (redirect_req),
    .redirect_pc_o     (redirect_pc)
  );

  fetch_ctrl_state_t state, next_state;
  logic [RC_W-1:0]   refill_cnt;
  logic              occ_high, occ_low;

  // Out-of-range occupancy compares above STALL_HI, so it stalls naturally.
  assign occ_high = (occupancy_i >= OCC_W'(STALL_HI));
  assign occ_low  = (occupancy_i <= OCC_W'(STALL_LO));

  always_comb begin
    next_state = state;
    if (redirect_req) begin
      next_state = ST_FLUSH;
    end else begin
      case (state)
        ST_RUN:    if (occ_high) next_state = ST_STALL;
        ST_FLUSH:  next_state = ST_REFILL;
        ST_REFILL: if (refill_cnt == '0) next_state = ST_RUN;
        ST_STALL:  if (occ_low) next_state = ST_RUN;
        default:   next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      flush_o      <= 1'b0;
      buble_o      <= 1'b0;
      correct_pc_o <= '0;
    end else begin
      state   <= next_state;
      flush_o <= (next_state == ST_FLUSH);
      buble_o <= (next_state == ST_STALL);
      if (redirect_req) correct_pc_o <= redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refill_cnt <= '0;
    end else if (state == ST_FLUSH && next_state == ST_REFILL) begin
      refill_cnt <= RC_W'(REFILL_CYCLES - 1);
    end else if (state == ST_REFILL && refill_cnt != '0) begin
      refill_cnt <= refill_cnt - 1'b1;
    end
  end

  // Counters advance on the same edge that raises flush_o / buble_o.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (next_state == ST_FLUSH && flush_count_o != '1)
        flush_count_o <= flush_count_o + 1'b1;
      if (next_state == ST_STALL && stall_count_o != '1)
        stall_count_o <= stall_count_o + 1'b1;
    end
  end

  assign state_o = state;

endmodule
